// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR ADC controller.
package sar_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    DONE
  } state_t;

  // Comparator verdict for the DAC code currently driven; 2'b11 is illegal.
  localparam logic [1:0] CMP_HIGH = 2'b00;
  localparam logic [1:0] CMP_LOW  = 2'b01;
  localparam logic [1:0] CMP_EQ   = 2'b10;

endpackage

// File: rtl/sar_reg.sv
// Successive-approximation register: trial-bit set/clear walking from MSB to LSB.
module sar_reg
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             keep,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] resolved_c,
  output logic             last_c
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] trial_c;

  assign last_c = (idx == '0);

  // Current trial with bit idx decided by the comparator.
  always_comb begin
    resolved_c      = value;
    resolved_c[idx] = keep;
  end

  // Next trial: decided code plus the next lower bit, unless this was the last bit.
  always_comb begin
    trial_c = resolved_c;
    if (!last_c) begin
      trial_c[idx - IW'(1)] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      idx   <= '0;
    end else if (load) begin
      value <= {1'b1, {(WIDTH-1){1'b0}}};
      idx   <= IW'(WIDTH - 1);
    end else if (step) begin
      value <= trial_c;
      if (!last_c) begin
        idx <= idx - IW'(1);
      end
    end
  end

endmodule

// File: rtl/sar_adc_controller.sv
// SAR ADC controller: sample, binary-search the DAC code, present result with valid.
// Optional early termination on an exact comparator match: define SAR_EARLY_EXIT_EN.
module sar_adc_controller
  import sar_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [1:0]       cmp,
  output logic             sample,
  output logic             valid,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  state_t           state_q;
  state_t           state_d;
  logic             keep_c;
  logic             eq_exit_c;
  logic             last_c;
  logic             load_c;
  logic             step_c;
  logic [WIDTH-1:0] resolved_c;

  // Illegal 2'b11 falls through to "too high" and clears the bit.
  assign keep_c = (cmp == CMP_LOW) || (cmp == CMP_EQ);

`ifdef SAR_EARLY_EXIT_EN
  assign eq_exit_c = (cmp == CMP_EQ);
`else
  assign eq_exit_c = 1'b0;
`endif

  sar_reg #(.WIDTH(WIDTH)) u_sar_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load_c),
    .step       (step_c),
    .keep       (keep_c),
    .value      (value),
    .resolved_c (resolved_c),
    .last_c     (last_c)
  );

  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) state_d = SAMPLE;
      end
      SAMPLE: begin
        load_c  = 1'b1;
        state_d = CONVERT;
      end
      CONVERT: begin
        // On an exact early match the code is already final, so the register holds.
        step_c = !eq_exit_c;
        if (last_c || eq_exit_c) state_d = DONE;
      end
      DONE: begin
        if (go) state_d = SAMPLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sample  <= 1'b0;
      valid   <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      sample  <= (state_d == SAMPLE);
      valid   <= (state_d == DONE);
      if ((state_q == CONVERT) && (state_d == DONE)) begin
        result <= resolved_c;
      end
    end
  end

endmodule

// File: tb/tb_sar_adc_controller.sv
// Directed plus randomized bench for sar_adc_controller with a behavioural comparator.
module tb_sar_adc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       go;
  logic [1:0] cmp;
  logic       sample;
  logic       valid;
  logic [7:0] value;
  logic [7:0] result;
  logic [7:0] vin;

  int tests  = 0;
  int failed = 0;
  int last_nconv;
  logic [7:0] trail [0:15];

  always #5 clk = ~clk;

  // Analog front end: comparator compares the DAC code with the held input.
  assign cmp = (value > vin) ? 2'b00 : ((value < vin) ? 2'b01 : 2'b10);

  sar_adc_controller #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .cmp    (cmp),
    .sample (sample),
    .valid  (valid),
    .value  (value),
    .result (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Number of CONVERT cycles: full length, or up to the trial equal to the input
  // (the trial for the lowest set bit of vin) when early exit is built in.
  function automatic int exp_nconv(input logic [7:0] v);
`ifdef SAR_EARLY_EXIT_EN
    int tz;
    if (v == 8'd0) return 8;
    tz = 0;
    while (((v >> tz) & 8'd1) == 8'd0) tz++;
    return 8 - tz;
`else
    return 8;
`endif
  endfunction

  // One conversion started by a single-cycle go pulse; edges counts the go-sampling edge as 1.
  task automatic run_conv(input logic [7:0] v, input string tag);
    int edges;
    int nconv;
    logic [7:0] prev;
    prev = result;
    vin  = v;
    go   = 1'b1;
    @(posedge clk); #1;
    go    = 1'b0;
    edges = 1;
    nconv = 0;
    check({tag, "_sample_hi"}, 32'(sample), 32'd1);
    check({tag, "_valid_lo"}, 32'(valid), 32'd0);
    while (valid !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 2) check({tag, "_sample_1cyc"}, 32'(sample), 32'd0);
      if (valid !== 1'b1) begin
        if (nconv < 16) trail[nconv] = value;
        nconv++;
        if (result !== prev) check({tag, "_result_persist"}, 32'(result), 32'(prev));
      end
    end
    last_nconv = nconv;
    check({tag, "_latency"}, 32'(edges), 32'(exp_nconv(v) + 2));
    check({tag, "_result"}, 32'(result), 32'(v));
    check({tag, "_value_held"}, 32'(value), 32'(v));
  endtask

  initial begin
    logic [7:0] exp_trail [0:7];
    logic [7:0] r;
    int e;

    rst = 1'b1;
    go  = 1'b0;
    vin = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sample", 32'(sample), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_value", 32'(value), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_valid", 32'(valid), 32'd0);

    run_conv(8'd64, "vin64");
    check("vin64_nconv", 32'(last_nconv), 32'(exp_nconv(8'd64)));
    run_conv(8'd0, "vin0");
    run_conv(8'd255, "vin255");

    exp_trail[0] = 8'h80; exp_trail[1] = 8'hC0; exp_trail[2] = 8'hA0; exp_trail[3] = 8'hB0;
    exp_trail[4] = 8'hA8; exp_trail[5] = 8'hAC; exp_trail[6] = 8'hAA; exp_trail[7] = 8'hAB;
    run_conv(8'd170, "vin170");
    for (int k = 0; k < exp_nconv(8'd170); k++) begin
      check($sformatf("trail170_%0d", k), 32'(trail[k]), 32'(exp_trail[k]));
    end

    // Reset during the 4th CONVERT cycle.
    vin = 8'd200;
    go  = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_sample", 32'(sample), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_value", 32'(value), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    @(posedge clk); #1;
    check("midrst_idle_value", 32'(value), 32'd0);
    check("midrst_idle_sample", 32'(sample), 32'd0);
    run_conv(8'd37, "vin37");

    // DONE holds with go low.
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(valid), 32'd1);
      check("hold_result", 32'(result), 32'd37);
    end

    run_conv(8'd99, "pulse99");

    // go held high: back-to-back conversions, DONE lasting one cycle.
    vin = 8'($urandom_range(0, 255));
    go  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = 0;
      do begin
        @(posedge clk); #1;
        e++;
        if (e == 1) begin
          check("b2b_sample", 32'(sample), 32'd1);
          check("b2b_valid_drop", 32'(valid), 32'd0);
        end
      end while (valid !== 1'b1 && e < 40);
      check("b2b_period", 32'(e), 32'(exp_nconv(vin) + 2));
      check("b2b_result", 32'(result), 32'(vin));
    end
    go = 1'b0;
    @(posedge clk); #1;
    e = 0;
    while (valid !== 1'b1 && e < 40) begin
      @(posedge clk); #1;
      e++;
    end
    check("b2b_drain", 32'(valid), 32'd1);

    for (int n = 0; n < 200; n++) begin
      r = 8'($urandom_range(0, 255));
      run_conv(r, $sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
